sram_responder: RTL and testbench
=================================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 14, word-address width; storage SHALL be 2^ADDR_WIDTH 32-bit words.
REQ-002 Parameter LATENCY, default 1, legal 1..4: clock edges from request acceptance to read data valid.
REQ-003 clk  input  1  clock; all state SHALL update on rising edge only.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sram_en  input  1  request strobe.
REQ-006 sram_wen  input  4  byte-lane write enables; nonzero = write, zero = read.
REQ-007 sram_addr  input  32  byte address; word index = sram_addr[ADDR_WIDTH+1:2]; bits [31:29] ignored.
REQ-008 sram_wdata  input  32  write data; lane i = bits [8i+7:8i].
REQ-009 sram_rdata  output  32  read data; holds last completed read value.
REQ-010 rdata_valid  output  1  one-cycle pulse when sram_rdata carries a new read result.
REQ-011 busy  output  1  high while a read is in flight and LATENCY>1; requests ignored while high.
REQ-012 err  output  1  one-cycle pulse flagging a rejected access.

Function
REQ-013 Request SHALL be accepted at an edge where sram_en=1 and busy=0; otherwise inputs ignored, no state change.
REQ-014 Accepted write SHALL update only lanes with sram_wen[i]=1 at the acceptance edge; no rdata_valid pulse; sram_rdata unchanged.
REQ-015 Accepted read SHALL sample the word at the acceptance edge (pre-write contents of that edge).
REQ-016 Read result SHALL appear on sram_rdata with rdata_valid=1 for exactly the cycle following edge acceptance+LATENCY-1 (LATENCY=1: the cycle right after acceptance).
REQ-017 States IDLE, WAIT: IDLE+accepted read with LATENCY>1 -> WAIT, down-counter loaded LATENCY-1; WAIT decrements each edge; counter reaching 0 -> IDLE with rdata_valid asserted.
REQ-018 busy SHALL equal (state==WAIT); with LATENCY=1 busy SHALL stay 0 and back-to-back reads SHALL be accepted every cycle.
REQ-019 A new request SHALL be acceptable in the same cycle rdata_valid is high.
REQ-020 Write followed by read of the same word on the next cycle SHALL return the written data.
REQ-021 Counter width 2 bits; no wrap beyond LATENCY-1.

Reset
REQ-022 rst=1 at an edge SHALL force state IDLE, counter 0, sram_rdata=32'h0, rdata_valid=0, busy=0, err=0.
REQ-023 Reset mid-read SHALL discard the pending read; no rdata_valid pulse afterwards for it.
REQ-024 Storage contents SHALL NOT be reset; a request presented with rst=1 SHALL be ignored.

Configuration
REQ-025 Macro SRAM_RESP_CHECK_EN defined: access with sram_addr[1:0]!=0 or any nonzero bit in sram_addr[28:ADDR_WIDTH+2] SHALL be rejected.
REQ-026 Rejected write: storage unchanged, err pulses in cycle after acceptance.
REQ-027 Rejected read: follows normal latency, sram_rdata=32'h0, rdata_valid and err pulse together.
REQ-028 Macro undefined: err tied 0, sram_addr[1:0] and out-of-range bits ignored (address aliases by truncation).

Verification
REQ-029 LATENCY=1: write 0xDEADBEEF to 0x100 wen=4'hF, then read 0x100 -> next cycle rdata=0xDEADBEEF, valid=1, busy=0.
REQ-030 Write 0x11223344 wen=4'hF, then 0xAABBCCDD wen=4'b0101 to 0x40, read -> 0x11BB33DD.
REQ-031 LATENCY=3: read 0x8 -> busy high 2 cycles, valid 3rd cycle after acceptance; read issued while busy ignored (no extra valid).
REQ-032 LATENCY=3: rst pulse one cycle after read accept -> busy=0, no valid pulse ever, rdata=0.
REQ-033 SRAM_RESP_CHECK_EN: read 0x102 -> valid=1, err=1, rdata=0; write to 0x102 -> err=1, word 0x100 unchanged.
REQ-034 LATENCY=1: reads to 0x0,0x4,0x8 on consecutive cycles -> three consecutive valid pulses with matching data.

Source files
------------

// File: rtl/sram_responder.sv
// sram_responder: single-port word SRAM model with byte-lane writes and configurable read latency.
// Optional address checking is enabled by defining SRAM_RESP_CHECK_EN.
module sram_responder #(
   parameter int ADDR_WIDTH = 14,
   parameter int LATENCY    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sram_en,
   input  logic [3:0]  sram_wen,
   input  logic [31:0] sram_addr,
   input  logic [31:0] sram_wdata,
   output logic [31:0] sram_rdata,
   output logic        rdata_valid,
   output logic        busy,
   output logic        err
);
   typedef enum logic {IDLE, WAIT} state_t;
   localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);
   state_t                r_state, w_state_nxt;
   logic [1:0]            r_cnt, w_cnt_nxt;
   logic                  w_accept, w_rd, w_wr, w_bad, w_done, w_unused;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic [31:0]           r_mem [0:(1<<ADDR_WIDTH)-1];
   logic [31:0]           r_rdata, r_pend;
   logic                  r_valid, r_err, r_pend_err;
   assign busy        = (r_state == WAIT);
   assign sram_rdata  = r_rdata;
   assign rdata_valid = r_valid;
   assign err         = r_err;
   assign w_accept    = sram_en & ~busy & ~rst;
   assign w_rd        = w_accept & ~|sram_wen;
   assign w_wr        = w_accept & |sram_wen;
   assign w_idx       = sram_addr[ADDR_WIDTH+1:2];
   assign w_unused    = ^{sram_addr[31:ADDR_WIDTH+2], sram_addr[1:0]};
`ifdef SRAM_RESP_CHECK_EN
   assign w_bad = |sram_addr[1:0] | |(sram_addr[28:0] >> (ADDR_WIDTH + 2));
`else
   assign w_bad = 1'b0;
`endif
   // state and latency counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end
   // next state: enter WAIT on a multi-cycle read, leave when the counter expires
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_done      = 1'b0;
      if (r_state == IDLE) begin
         if (w_rd && LATENCY > 1) begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_INIT;
         end
      end else begin
         w_cnt_nxt = r_cnt - 2'd1;
         if (r_cnt == 2'd1) begin
            w_state_nxt = IDLE;
            w_done      = 1'b1;
         end
      end
   end
   // read result, valid/err pulses; pending read data is captured at acceptance
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata    <= 32'h0;
         r_valid    <= 1'b0;
         r_err      <= 1'b0;
         r_pend     <= 32'h0;
         r_pend_err <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_err   <= w_wr & w_bad;
         if (w_done) begin
            r_rdata <= r_pend;
            r_valid <= 1'b1;
            r_err   <= r_pend_err;
         end
         if (w_rd) begin
            if (LATENCY == 1) begin
               r_rdata <= w_bad ? 32'h0 : r_mem[w_idx];
               r_valid <= 1'b1;
               r_err   <= w_bad;
            end else begin
               r_pend     <= w_bad ? 32'h0 : r_mem[w_idx];
               r_pend_err <= w_bad;
            end
         end
      end
   end
   // storage: byte-lane writes, never reset
   always_ff @(posedge clk) begin
      if (w_wr && !w_bad)
         for (int i = 0; i < 4; i++)
            if (sram_wen[i]) r_mem[w_idx][8*i+:8] <= sram_wdata[8*i+:8];
   end
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed checks of sram_responder at LATENCY=1 and LATENCY=3.
module tb_sram_responder;
   logic        clk = 1'b0;
   logic        a_rst, a_en, a_valid, a_busy, a_err;
   logic [3:0]  a_wen;
   logic [31:0] a_addr, a_wdata, a_rdata;
   logic        b_rst, b_en, b_valid, b_busy, b_err;
   logic [3:0]  b_wen;
   logic [31:0] b_addr, b_wdata, b_rdata;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   sram_responder #(.ADDR_WIDTH(14), .LATENCY(1)) u_a (
      .clk(clk), .rst(a_rst), .sram_en(a_en), .sram_wen(a_wen), .sram_addr(a_addr),
      .sram_wdata(a_wdata), .sram_rdata(a_rdata), .rdata_valid(a_valid), .busy(a_busy), .err(a_err));

   sram_responder #(.ADDR_WIDTH(14), .LATENCY(3)) u_b (
      .clk(clk), .rst(b_rst), .sram_en(b_en), .sram_wen(b_wen), .sram_addr(b_addr),
      .sram_wdata(b_wdata), .sram_rdata(b_rdata), .rdata_valid(b_valid), .busy(b_busy), .err(b_err));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic a_req(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd);
      a_en = en; a_wen = wen; a_addr = addr; a_wdata = wd;
   endtask

   task automatic b_req(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd);
      b_en = en; b_wen = wen; b_addr = addr; b_wdata = wd;
   endtask

   initial begin
      a_rst = 1'b1; b_rst = 1'b1;
      a_req(1'b0, 4'h0, 32'h0, 32'h0);
      b_req(1'b0, 4'h0, 32'h0, 32'h0);
      step(); step();
      chk("a_rst_rdata", a_rdata, 32'h0);
      chk("a_rst_valid", {31'h0, a_valid}, 32'h0);
      chk("a_rst_busy", {31'h0, a_busy}, 32'h0);
      chk("a_rst_err", {31'h0, a_err}, 32'h0);
      chk("b_rst_busy", {31'h0, b_busy}, 32'h0);
      a_rst = 1'b0; b_rst = 1'b0;
      // write then immediate read
      a_req(1'b1, 4'hF, 32'h100, 32'hDEADBEEF); step();
      chk("wr_no_valid", {31'h0, a_valid}, 32'h0);
      a_req(1'b1, 4'h0, 32'h100, 32'h0); step();
      chk("rd100_data", a_rdata, 32'hDEADBEEF);
      chk("rd100_valid", {31'h0, a_valid}, 32'h1);
      chk("rd100_busy", {31'h0, a_busy}, 32'h0);
      a_req(1'b0, 4'h0, 32'h0, 32'h0); step();
      chk("idle_valid", {31'h0, a_valid}, 32'h0);
      chk("idle_hold", a_rdata, 32'hDEADBEEF);
      // partial lane write
      a_req(1'b1, 4'hF, 32'h40, 32'h11223344); step();
      a_req(1'b1, 4'b0101, 32'h40, 32'hAABBCCDD); step();
      chk("lane_wr_keeps_rdata", a_rdata, 32'hDEADBEEF);
      a_req(1'b1, 4'h0, 32'h40, 32'h0); step();
      chk("lane_data", a_rdata, 32'h11BB33DD);
      chk("lane_valid", {31'h0, a_valid}, 32'h1);
      // back-to-back reads
      a_req(1'b1, 4'hF, 32'h0, 32'hA0A0A0A0); step();
      a_req(1'b1, 4'hF, 32'h4, 32'hA4A4A4A4); step();
      a_req(1'b1, 4'hF, 32'h8, 32'hA8A8A8A8); step();
      a_req(1'b1, 4'h0, 32'h0, 32'h0); step();
      chk("b2b0_data", a_rdata, 32'hA0A0A0A0);
      chk("b2b0_valid", {31'h0, a_valid}, 32'h1);
      a_req(1'b1, 4'h0, 32'h4, 32'h0); step();
      chk("b2b1_data", a_rdata, 32'hA4A4A4A4);
      chk("b2b1_valid", {31'h0, a_valid}, 32'h1);
      a_req(1'b1, 4'h0, 32'h8, 32'h0); step();
      chk("b2b2_data", a_rdata, 32'hA8A8A8A8);
      chk("b2b2_valid", {31'h0, a_valid}, 32'h1);
      // request during reset is ignored, storage survives reset
      a_rst = 1'b1;
      a_req(1'b1, 4'hF, 32'h100, 32'h00000055); step();
      chk("rst_clr_rdata", a_rdata, 32'h0);
      chk("rst_clr_valid", {31'h0, a_valid}, 32'h0);
      a_rst = 1'b0;
      a_req(1'b1, 4'h0, 32'h100, 32'h0); step();
      chk("mem_kept", a_rdata, 32'hDEADBEEF);
`ifdef SRAM_RESP_CHECK_EN
      a_req(1'b1, 4'h0, 32'h102, 32'h0); step();
      chk("badrd_valid", {31'h0, a_valid}, 32'h1);
      chk("badrd_err", {31'h0, a_err}, 32'h1);
      chk("badrd_data", a_rdata, 32'h0);
      a_req(1'b1, 4'hF, 32'h102, 32'h12345678); step();
      chk("badwr_err", {31'h0, a_err}, 32'h1);
      chk("badwr_valid", {31'h0, a_valid}, 32'h0);
      a_req(1'b1, 4'h0, 32'h100, 32'h0); step();
      chk("badwr_unchanged", a_rdata, 32'hDEADBEEF);
      chk("goodrd_err", {31'h0, a_err}, 32'h0);
      a_req(1'b1, 4'h0, 32'h10100, 32'h0); step();
      chk("highbit_err", {31'h0, a_err}, 32'h1);
      chk("highbit_data", a_rdata, 32'h0);
`else
      a_req(1'b1, 4'h0, 32'h10102, 32'h0); step();
      chk("alias_rd_data", a_rdata, 32'hDEADBEEF);
      chk("alias_rd_err", {31'h0, a_err}, 32'h0);
      a_req(1'b1, 4'hF, 32'hE0010101, 32'hCAFEF00D); step();
      chk("alias_wr_err", {31'h0, a_err}, 32'h0);
      a_req(1'b1, 4'h0, 32'h100, 32'h0); step();
      chk("alias_wr_data", a_rdata, 32'hCAFEF00D);
`endif
      a_req(1'b0, 4'h0, 32'h0, 32'h0);
      // LATENCY=3 read with an ignored request while busy
      b_req(1'b1, 4'hF, 32'h8, 32'h0BADF00D); step();
      chk("l3_wr_busy", {31'h0, b_busy}, 32'h0);
      chk("l3_wr_valid", {31'h0, b_valid}, 32'h0);
      b_req(1'b1, 4'h0, 32'h8, 32'h0); step();
      chk("l3_c1_busy", {31'h0, b_busy}, 32'h1);
      chk("l3_c1_valid", {31'h0, b_valid}, 32'h0);
      step();
      chk("l3_c2_busy", {31'h0, b_busy}, 32'h1);
      chk("l3_c2_valid", {31'h0, b_valid}, 32'h0);
      b_req(1'b0, 4'h0, 32'h0, 32'h0); step();
      chk("l3_c3_busy", {31'h0, b_busy}, 32'h0);
      chk("l3_c3_valid", {31'h0, b_valid}, 32'h1);
      chk("l3_c3_data", b_rdata, 32'h0BADF00D);
      chk("l3_c3_err", {31'h0, b_err}, 32'h0);
      step();
      chk("l3_c4_valid", {31'h0, b_valid}, 32'h0);
      step();
      chk("l3_c5_valid", {31'h0, b_valid}, 32'h0);
      chk("l3_c5_busy", {31'h0, b_busy}, 32'h0);
      // reset while a read is in flight
      b_rst = 1'b1; step(); b_rst = 1'b0;
      b_req(1'b1, 4'h0, 32'h8, 32'h0); step();
      b_req(1'b0, 4'h0, 32'h0, 32'h0);
      chk("l3_rr_busy", {31'h0, b_busy}, 32'h1);
      b_rst = 1'b1; step(); b_rst = 1'b0;
      chk("l3_rr_busy0", {31'h0, b_busy}, 32'h0);
      chk("l3_rr_rdata0", b_rdata, 32'h0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("l3_rr_novalid", {31'h0, b_valid}, 32'h0);
      end
      chk("l3_rr_rdata_end", b_rdata, 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
